apr_event_ctl: RTL and testbench
================================

Name: apr_event_ctl

Overview:
Parametrised successor to the EBOX APR error/interrupt flag logic. It serves NCHAN event channels, each with a sticky flag, an interrupt enable, per-channel edge or level detection, and a saturating occurrence counter. CONO-style set/clear/enable/disable strobes, a loadable PIA, a registered "any error" summary and a one-cycle-latency diagnostic readback are provided. It sits between MBOX/power/sweep event sources, the CON strobes, the EBUS and PI.

Parameters:
NCHAN, 8, number of event channels (1..DW-BASE)
DW, 36, EBUS data width; bits numbered 0..DW-1, bit 0 is MSB
BASE, 6, EBUS bit carrying channel 0; channel i maps to bit BASE+i
PIA_BASE, 33, EBUS bit of PIA MSB; PIA occupies PIA_BASE..PIA_BASE+2
CNT_W, 8, width of each per-channel occurrence counter
EDGE_MASK, 8'h80, bit i=1: channel i uses rising-edge detection; 0: level detection
ERR_MASK, 8'h2A, bit i=1: channel i contributes to ANY_ERR_FLG

Ports:
clk  input  1  processor clock
RESET_N  input  1  reset; one clock; reset is synchronous and active-low
EV_IN  input  NCHAN  raw event sources
DATA_IN  input  DW  EBUS data for CONO/DATAO
SEL_SET  input  1  set flags whose channel bits are 1
SEL_CLR  input  1  clear flags, counters and overflow bits whose channel bits are 1
SEL_EN  input  1  set interrupt enables whose channel bits are 1
SEL_DIS  input  1  clear interrupt enables whose channel bits are 1
LOAD_PIA  input  1  load PIA from DATA_IN[PIA_BASE+:3]
RD_EN  input  1  diagnostic read request
RD_SEL  input  3  read function
RD_CH  input  clog2(NCHAN)  counter channel for RD_SEL=4
RD_DATA  output  DW  registered readback
RD_VALID  output  1  RD_DATA valid
FLAGS  output  NCHAN  sticky event flags
INT_EN  output  NCHAN  interrupt enables
INTERRUPT  output  1  OR over FLAGS & INT_EN
INT_PIA  output  3  PIA when INTERRUPT=1, else 0
ANY_ERR_FLG  output  1  registered error summary

Behaviour:
- Reset (RESET_N=0 at a clk edge): FLAGS, INT_EN, PIA, counters, OVF, edge-history, RD_DATA, RD_VALID and ANY_ERR_FLG all 0. Strobes and events are ignored during reset.
- Edge history: ev_q[i] <= EV_IN[i] every cycle.
- Detection det[i]:
  - EDGE_MASK[i]=1: det[i] = EV_IN[i] & ~ev_q[i].
  - EDGE_MASK[i]=0: det[i] = EV_IN[i].
  - An input already high when reset is released produces an edge on the first cycle after release.
- Let m[i] = DATA_IN[BASE+i].
- Flag next state: flag_n[i] = det[i] | SEL_SET&m[i] | FLAGS[i]&~(SEL_CLR&m[i]).
  - Detect or set in the same cycle as clear: set wins.
  - FLAGS updates one cycle after the cause.
- Enable next state: INT_EN[i] <= SEL_EN&m[i] | INT_EN[i]&~(SEL_DIS&m[i]). SEL_EN and SEL_DIS together: enable wins.
- INTERRUPT and INT_PIA are combinational from registered state. PIA holds its value until the next LOAD_PIA.
- ANY_ERR_FLG <= |(flag_n & ERR_MASK). It is one cycle after the event, the same cycle FLAGS shows it.
- Counter cnt[i]:
  - Increments on det[i].
  - Saturates at 2^CNT_W-1; an increment attempted at saturation sets sticky OVF[i].
  - SEL_CLR&m[i] clears cnt[i] and OVF[i]. If det[i] occurs in the same cycle, cnt[i] becomes 1 and OVF[i] becomes 0.
  - SEL_SET does not count.
- Readback: on RD_EN, at the next edge RD_DATA is loaded and RD_VALID=1; otherwise RD_VALID=0 and RD_DATA holds. Unused bits are 0.
  - RD_SEL 0: FLAGS at BASE+i.
  - RD_SEL 1: INT_EN at BASE+i.
  - RD_SEL 2: ev_q at BASE+i.
  - RD_SEL 3: INTERRUPT at bit 0, ANY_ERR_FLG at bit 1, PIA at PIA_BASE.
  - RD_SEL 4: cnt[RD_CH] right-justified at DW-1, OVF[RD_CH] at bit 0.
  - RD_SEL 5..7, or RD_CH>=NCHAN: all zeros.
  - Readback samples state before the same-edge update.
- Reset mid-operation overrides every strobe and event in that cycle.

Test Plan:
- Reset, then SEL_EN with m=8'h02 and EV_IN[1] pulsed one cycle. Required: FLAGS=8'h02 one cycle later; INTERRUPT=1; INT_PIA=0 before LOAD_PIA; INT_PIA=5 after LOAD_PIA with DATA_IN[33:35]=3'b101; ANY_ERR_FLG=1 in the same cycle as FLAGS.
- EV_IN[7] (edge channel) held high for 10 cycles. Required: FLAGS[7] set once; cnt[7]=1 via RD_SEL=4, RD_CH=7. EV_IN[0] (level) held high for 10 cycles. Required: cnt[0]=10.
- SEL_CLR with m[1]=1 in the same cycle as EV_IN[1]. Required: FLAGS[1] stays 1, cnt[1]=1. SEL_CLR alone. Required: FLAGS[1]=0, INTERRUPT=0.
- EV_IN[0] level held high for 300 cycles with CNT_W=8. Required: cnt[0]=255, OVF[0]=1 (RD_DATA bit 0 set); after SEL_CLR both are 0.
- SEL_EN and SEL_DIS together with m=8'hFF. Required: INT_EN=8'hFF. RD_SEL=6. Required: RD_DATA=0 with RD_VALID=1.
- RESET_N low for one cycle while flags, enables, PIA and counters are nonzero and SEL_SET is asserted. Required: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/apr_event_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : apr_event_ctl_if
// Purpose  : Event-source, CONO/DATAO strobe and diagnostic-readback bundle
//            for apr_event_ctl.
// Revision : 1.0
// ============================================================================
interface apr_event_ctl_if #(
    parameter int NCHAN = 8,
    parameter int DW    = 36,
    parameter int CH_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1
);
    logic [NCHAN-1:0] EV_IN;
    logic [DW-1:0]    DATA_IN;
    logic             SEL_SET;
    logic             SEL_CLR;
    logic             SEL_EN;
    logic             SEL_DIS;
    logic             LOAD_PIA;
    logic             RD_EN;
    logic [2:0]       RD_SEL;
    logic [CH_W-1:0]  RD_CH;
    logic [DW-1:0]    RD_DATA;
    logic             RD_VALID;
    logic [NCHAN-1:0] FLAGS;
    logic [NCHAN-1:0] INT_EN;
    logic             INTERRUPT;
    logic [2:0]       INT_PIA;
    logic             ANY_ERR_FLG;

    modport master (
        output EV_IN, DATA_IN, SEL_SET, SEL_CLR, SEL_EN, SEL_DIS, LOAD_PIA,
               RD_EN, RD_SEL, RD_CH,
        input  RD_DATA, RD_VALID, FLAGS, INT_EN, INTERRUPT, INT_PIA, ANY_ERR_FLG
    );

    modport slave (
        input  EV_IN, DATA_IN, SEL_SET, SEL_CLR, SEL_EN, SEL_DIS, LOAD_PIA,
               RD_EN, RD_SEL, RD_CH,
        output RD_DATA, RD_VALID, FLAGS, INT_EN, INTERRUPT, INT_PIA, ANY_ERR_FLG
    );
endinterface
`default_nettype wire

// File: rtl/apr_event_ctl.sv
`default_nettype none
// ============================================================================
// Module   : apr_event_ctl
// Purpose  : APR event flags, interrupt enables, PIA, saturating per-channel
//            occurrence counters and registered diagnostic readback.
// Revision : 1.0
// ============================================================================
module apr_event_ctl #(
    parameter int               NCHAN     = 8,
    parameter int               DW        = 36,
    parameter int               BASE      = 6,
    parameter int               PIA_BASE  = 33,
    parameter int               CNT_W     = 8,
    parameter logic [NCHAN-1:0] EDGE_MASK = 8'h80,
    parameter logic [NCHAN-1:0] ERR_MASK  = 8'h2A
) (
    input  logic          clk,
    input  logic          RESET_N,
    apr_event_ctl_if.slave bus
);
    // EBUS bit k (bit 0 = MSB) lives at vector index DW-1-k.
    localparam int               C_CH_W    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int               C_TAB     = 1 << C_CH_W;
    localparam int               C_CH_MSB  = DW - 1 - BASE;
    localparam int               C_PIA_MSB = DW - 1 - PIA_BASE;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [NCHAN-1:0]            r_flags;
    logic [NCHAN-1:0]            r_int_en;
    logic [NCHAN-1:0]            r_ev_q;
    logic [NCHAN-1:0]            r_ovf;
    logic [NCHAN-1:0][CNT_W-1:0] r_cnt;
    logic [2:0]                  r_pia;
    logic                        r_any_err;
    logic                        r_rd_valid;
    logic [DW-1:0]               r_rd_data;

    logic [NCHAN-1:0]            w_m;
    logic [NCHAN-1:0]            w_det;
    logic [NCHAN-1:0]            w_flag_n;
    logic [NCHAN-1:0]            w_en_n;
    logic                        w_interrupt;
    logic [DW-1:0]               w_rd_data;
    logic [CNT_W:0]              w_cnt_tab [C_TAB];

    always_comb begin
        w_m   = '0;
        w_det = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_m[i]   = bus.DATA_IN[C_CH_MSB-i];
            w_det[i] = EDGE_MASK[i] ? (bus.EV_IN[i] & ~r_ev_q[i]) : bus.EV_IN[i];
        end
        // Set and detect dominate clear; enable dominates disable.
        w_flag_n = w_det | ({NCHAN{bus.SEL_SET}} & w_m)
                 | (r_flags & ~({NCHAN{bus.SEL_CLR}} & w_m));
        w_en_n   = ({NCHAN{bus.SEL_EN}} & w_m)
                 | (r_int_en & ~({NCHAN{bus.SEL_DIS}} & w_m));
    end

    assign w_interrupt = |(r_flags & r_int_en);

    // Pad the counter view to a power of two so out-of-range RD_CH reads zero.
    for (genvar j = 0; j < C_TAB; j++) begin : g_cnt_tab
        if (j < NCHAN) begin : g_live
            assign w_cnt_tab[j] = {r_cnt[j], r_ovf[j]};
        end else begin : g_pad
            assign w_cnt_tab[j] = '0;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (bus.RD_SEL)
            3'd0: for (int i = 0; i < NCHAN; i++) w_rd_data[C_CH_MSB-i] = r_flags[i];
            3'd1: for (int i = 0; i < NCHAN; i++) w_rd_data[C_CH_MSB-i] = r_int_en[i];
            3'd2: for (int i = 0; i < NCHAN; i++) w_rd_data[C_CH_MSB-i] = r_ev_q[i];
            3'd3: begin
                w_rd_data[DW-1]            = w_interrupt;
                w_rd_data[DW-2]            = r_any_err;
                w_rd_data[C_PIA_MSB -: 3]  = r_pia;
            end
            3'd4: begin
                w_rd_data[CNT_W-1:0] = w_cnt_tab[bus.RD_CH][CNT_W:1];
                w_rd_data[DW-1]      = w_cnt_tab[bus.RD_CH][0];
            end
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            r_flags    <= '0;
            r_int_en   <= '0;
            r_ev_q     <= '0;
            r_ovf      <= '0;
            r_cnt      <= '0;
            r_pia      <= '0;
            r_any_err  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_flags    <= w_flag_n;
            r_int_en   <= w_en_n;
            r_ev_q     <= bus.EV_IN;
            r_any_err  <= |(w_flag_n & ERR_MASK);
            r_rd_valid <= bus.RD_EN;
            if (bus.RD_EN) begin
                r_rd_data <= w_rd_data;
            end
            if (bus.LOAD_PIA) begin
                r_pia <= bus.DATA_IN[C_PIA_MSB -: 3];
            end
            for (int i = 0; i < NCHAN; i++) begin
                if (bus.SEL_CLR && w_m[i]) begin
                    r_cnt[i] <= w_det[i] ? C_CNT_ONE : '0;
                    r_ovf[i] <= 1'b0;
                end else if (w_det[i]) begin
                    if (r_cnt[i] == C_CNT_MAX) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
                    end
                end
            end
        end
    end

    assign bus.FLAGS       = r_flags;
    assign bus.INT_EN      = r_int_en;
    assign bus.INTERRUPT   = w_interrupt;
    assign bus.INT_PIA     = w_interrupt ? r_pia : 3'd0;
    assign bus.ANY_ERR_FLG = r_any_err;
    assign bus.RD_DATA     = r_rd_data;
    assign bus.RD_VALID    = r_rd_valid;
endmodule
`default_nettype wire

// File: tb/tb_apr_event_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apr_event_ctl
// Purpose  : Directed plus randomized bench for apr_event_ctl against a
//            channel-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_apr_event_ctl;
    localparam int         NCHAN     = 8;
    localparam int         DW        = 36;
    localparam int         BASE      = 6;
    localparam int         PIA_BASE  = 33;
    localparam int         CNT_W     = 8;
    localparam logic [7:0] EDGE_MASK = 8'h80;
    localparam logic [7:0] ERR_MASK  = 8'h2A;
    localparam int         CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic RESET_N;
    always #5 clk = ~clk;

    apr_event_ctl_if #(.NCHAN(NCHAN), .DW(DW)) bus ();

    apr_event_ctl #(
        .NCHAN(NCHAN), .DW(DW), .BASE(BASE), .PIA_BASE(PIA_BASE), .CNT_W(CNT_W),
        .EDGE_MASK(EDGE_MASK), .ERR_MASK(ERR_MASK)
    ) u_dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit            m_flag [NCHAN];
    bit            m_en   [NCHAN];
    bit            m_ovf  [NCHAN];
    bit            m_evq  [NCHAN];
    int            m_cnt  [NCHAN];
    int            m_pia;
    bit            m_any_err;
    bit            m_rd_valid;
    logic [DW-1:0] m_rd_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // EBUS numbering: bit 0 is the MSB of the DW-bit word.
    function automatic bit ebus(input logic [DW-1:0] d, input int k);
        return d[DW-1-k];
    endfunction

    function automatic logic [DW-1:0] mask_data(input logic [7:0] m);
        logic [DW-1:0] d = '0;
        for (int i = 0; i < NCHAN; i++) d[DW-1-(BASE+i)] = m[i];
        return d;
    endfunction

    function automatic logic [DW-1:0] pia_data(input logic [2:0] p);
        logic [DW-1:0] d = '0;
        d[DW-1-PIA_BASE]     = p[2];
        d[DW-1-(PIA_BASE+1)] = p[1];
        d[DW-1-(PIA_BASE+2)] = p[0];
        return d;
    endfunction

    function automatic logic [NCHAN-1:0] pack(input bit a [NCHAN]);
        logic [NCHAN-1:0] v;
        for (int i = 0; i < NCHAN; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic bit model_intr();
        for (int i = 0; i < NCHAN; i++) if (m_flag[i] && m_en[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_read(input int sel, input int ch);
        logic [DW-1:0] r = '0;
        int c;
        case (sel)
            0: for (int i = 0; i < NCHAN; i++) r[DW-1-(BASE+i)] = m_flag[i];
            1: for (int i = 0; i < NCHAN; i++) r[DW-1-(BASE+i)] = m_en[i];
            2: for (int i = 0; i < NCHAN; i++) r[DW-1-(BASE+i)] = m_evq[i];
            3: begin
                r[DW-1] = model_intr();
                r[DW-2] = m_any_err;
                for (int b = 0; b < 3; b++) r[DW-1-(PIA_BASE+b)] = ((m_pia >> (2-b)) & 1) != 0;
            end
            4: if (ch < NCHAN) begin
                c = m_cnt[ch];
                r[CNT_W-1:0] = c[CNT_W-1:0];
                r[DW-1] = m_ovf[ch];
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // One clock: advance the model on the current inputs, then compare.
    task automatic step();
        bit det, mm, intr;
        if (!RESET_N) begin
            for (int i = 0; i < NCHAN; i++) begin
                m_flag[i] = 0; m_en[i] = 0; m_ovf[i] = 0; m_evq[i] = 0; m_cnt[i] = 0;
            end
            m_pia = 0; m_any_err = 0; m_rd_valid = 0; m_rd_data = '0;
        end else begin
            if (bus.RD_EN) m_rd_data = model_read(int'(bus.RD_SEL), int'(bus.RD_CH));
            m_rd_valid = bus.RD_EN;
            for (int i = 0; i < NCHAN; i++) begin
                mm  = ebus(bus.DATA_IN, BASE + i);
                det = EDGE_MASK[i] ? (bus.EV_IN[i] && !m_evq[i]) : bus.EV_IN[i];
                m_flag[i] = det || (bus.SEL_SET && mm) || (m_flag[i] && !(bus.SEL_CLR && mm));
                m_en[i]   = (bus.SEL_EN && mm) || (m_en[i] && !(bus.SEL_DIS && mm));
                if (bus.SEL_CLR && mm) begin
                    m_cnt[i] = det ? 1 : 0;
                    m_ovf[i] = 0;
                end else if (det) begin
                    if (m_cnt[i] == CNT_MAX) m_ovf[i] = 1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end
                m_evq[i] = bus.EV_IN[i];
            end
            if (bus.LOAD_PIA)
                m_pia = 4 * ebus(bus.DATA_IN, PIA_BASE) + 2 * ebus(bus.DATA_IN, PIA_BASE + 1)
                      + ebus(bus.DATA_IN, PIA_BASE + 2);
            m_any_err = 0;
            for (int i = 0; i < NCHAN; i++) if (m_flag[i] && ERR_MASK[i]) m_any_err = 1;
        end
        @(posedge clk);
        #1;
        intr = model_intr();
        check_eq("flags",     bus.FLAGS,       pack(m_flag));
        check_eq("int_en",    bus.INT_EN,      pack(m_en));
        check_eq("interrupt", bus.INTERRUPT,   intr);
        check_eq("int_pia",   bus.INT_PIA,     intr ? m_pia : 0);
        check_eq("any_err",   bus.ANY_ERR_FLG, m_any_err);
        check_eq("rd_valid",  bus.RD_VALID,    m_rd_valid);
        check_eq("rd_data",   bus.RD_DATA,     m_rd_data);
    endtask

    task automatic idle();
        bus.DATA_IN = '0; bus.SEL_SET = 0; bus.SEL_CLR = 0; bus.SEL_EN = 0;
        bus.SEL_DIS = 0; bus.LOAD_PIA = 0; bus.RD_EN = 0; bus.RD_SEL = '0; bus.RD_CH = '0;
    endtask

    task automatic rd(input int sel, input int ch);
        idle();
        bus.RD_EN = 1; bus.RD_SEL = 3'(sel); bus.RD_CH = 3'(ch);
        step();
        idle();
    endtask

    initial begin
        RESET_N = 0; bus.EV_IN = '0; idle();
        step();
        check_eq("rst_flags", bus.FLAGS, 8'h00);
        RESET_N = 1;

        // Enable channel 1, pulse its event.
        bus.DATA_IN = mask_data(8'h02); bus.SEL_EN = 1;
        step();
        idle(); bus.EV_IN = 8'h02;
        step();
        bus.EV_IN = '0;
        check_eq("t1_flags", bus.FLAGS, 8'h02);
        check_eq("t1_intr", bus.INTERRUPT, 1'b1);
        check_eq("t1_pia0", bus.INT_PIA, 3'd0);
        check_eq("t1_err", bus.ANY_ERR_FLG, 1'b1);
        bus.DATA_IN = pia_data(3'b101); bus.LOAD_PIA = 1;
        step();
        idle();
        check_eq("t1_pia5", bus.INT_PIA, 3'd5);

        // Edge channel 7 vs level channel 0 held high.
        bus.EV_IN = 8'h80;
        for (int k = 0; k < 10; k++) step();
        bus.EV_IN = '0;
        check_eq("t2_flag7", bus.FLAGS[7], 1'b1);
        rd(4, 7);
        check_eq("t2_cnt7", bus.RD_DATA, 36'd1);
        bus.EV_IN = 8'h01;
        for (int k = 0; k < 10; k++) step();
        bus.EV_IN = '0;
        rd(4, 0);
        check_eq("t2_cnt0", bus.RD_DATA, 36'd10);

        // Clear collides with detect, then clear alone.
        bus.DATA_IN = mask_data(8'h02); bus.SEL_CLR = 1; bus.EV_IN = 8'h02;
        step();
        bus.EV_IN = '0;
        check_eq("t3_flag1", bus.FLAGS[1], 1'b1);
        rd(4, 1);
        check_eq("t3_cnt1", bus.RD_DATA, 36'd1);
        bus.DATA_IN = mask_data(8'h02); bus.SEL_CLR = 1;
        step();
        idle();
        check_eq("t3_flag1_clr", bus.FLAGS[1], 1'b0);
        check_eq("t3_intr", bus.INTERRUPT, 1'b0);

        // Saturation and overflow.
        bus.EV_IN = 8'h01;
        for (int k = 0; k < 300; k++) step();
        bus.EV_IN = '0;
        rd(4, 0);
        check_eq("t4_sat", bus.RD_DATA[7:0], 8'hFF);
        check_eq("t4_ovf", bus.RD_DATA[DW-1], 1'b1);
        bus.DATA_IN = mask_data(8'h01); bus.SEL_CLR = 1;
        step();
        rd(4, 0);
        check_eq("t4_clr", bus.RD_DATA, 36'd0);

        // Enable beats disable; unused read function.
        bus.DATA_IN = mask_data(8'hFF); bus.SEL_EN = 1; bus.SEL_DIS = 1;
        step();
        idle();
        check_eq("t5_en", bus.INT_EN, 8'hFF);
        rd(6, 0);
        check_eq("t5_rd6", bus.RD_DATA, 36'd0);
        check_eq("t5_vld", bus.RD_VALID, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 500; k++) begin
            RESET_N      = ($urandom_range(0, 60) != 0);
            bus.EV_IN    = 8'($urandom) & 8'($urandom);
            bus.DATA_IN  = DW'({$urandom(), $urandom()});
            bus.SEL_SET  = ($urandom_range(0, 7) == 0);
            bus.SEL_CLR  = ($urandom_range(0, 5) == 0);
            bus.SEL_EN   = ($urandom_range(0, 5) == 0);
            bus.SEL_DIS  = ($urandom_range(0, 5) == 0);
            bus.LOAD_PIA = ($urandom_range(0, 7) == 0);
            bus.RD_EN    = ($urandom_range(0, 1) == 0);
            bus.RD_SEL   = 3'($urandom_range(0, 7));
            bus.RD_CH    = 3'($urandom_range(0, 7));
            step();
        end
        RESET_N = 1; idle(); bus.EV_IN = '0;
        step();

        // Reset overrides a busy cycle.
        bus.DATA_IN = mask_data(8'hFF) | pia_data(3'b111);
        bus.SEL_SET = 1; bus.SEL_EN = 1; bus.LOAD_PIA = 1; bus.EV_IN = 8'hFF;
        step();
        bus.RD_EN = 1; bus.RD_SEL = 3'd0;
        step();
        RESET_N = 0;
        step();
        check_eq("t6_flags", bus.FLAGS, 8'h00);
        check_eq("t6_en", bus.INT_EN, 8'h00);
        check_eq("t6_intr", bus.INTERRUPT, 1'b0);
        check_eq("t6_pia", bus.INT_PIA, 3'd0);
        check_eq("t6_err", bus.ANY_ERR_FLG, 1'b0);
        check_eq("t6_vld", bus.RD_VALID, 1'b0);
        check_eq("t6_rd", bus.RD_DATA, 36'd0);
        RESET_N = 1; bus.EV_IN = '0;
        rd(4, 0);
        check_eq("t6_cnt0", bus.RD_DATA, 36'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
